// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RV32I fetch stage: PC, single-outstanding memory request FSM, instruction FIFO
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        fault
);

    localparam int             PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int             CW      = PW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t         r_state;
    logic [31:0]    r_pc;
    logic [31:0]    r_addr;
    logic           r_discard;
    logic [31:0]    r_fifo_instr [FIFO_DEPTH];
    logic [31:0]    r_fifo_pc    [FIFO_DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;

    logic           w_ack;
    logic           w_push;
    logic           w_pop;
    logic           w_redirect_ok;
    logic           w_fault_next;
    logic           w_go_idle;
    logic           w_go_ack;
    logic [CW-1:0]  w_count_next;
    logic [31:0]    w_pc_next;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_fault;

    // A misaligned target leaves the PC untouched and parks the fetcher until an aligned redirect.
    assign w_redirect_ok = redirect & (redirect_pc[1:0] == 2'b00);

    always_comb begin
        w_fault_next = r_fault;
        if (redirect) begin
            w_fault_next = (redirect_pc[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_fault_next;
        end
    end

    assign fault = r_fault;
`else
    logic w_unused_lsb;

    assign w_unused_lsb  = ^redirect_pc[1:0];
    assign w_redirect_ok = redirect;
    assign w_fault_next  = 1'b0;
    assign fault         = 1'b0;
`endif

    assign w_ack  = (r_state == S_REQ) & mem_ack;
    assign w_push = w_ack & ~r_discard & ~redirect;
    assign w_pop  = out_valid & out_ready & ~redirect;

    always_comb begin
        w_count_next = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
        if (redirect) begin
            w_count_next = '0;
        end
    end

    // A discarded ack belongs to the old stream, so the PC already holds the redirect target.
    always_comb begin
        w_pc_next = r_pc;
        if (w_redirect_ok) begin
            w_pc_next = {redirect_pc[31:2], 2'b00};
        end else if (w_ack && !r_discard) begin
            w_pc_next = r_pc + 32'd4;
        end
    end

    assign w_go_idle = (r_count < DEPTH_C) & ~redirect & ~w_fault_next;
    assign w_go_ack  = (w_count_next < DEPTH_C) & ~redirect & ~w_fault_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_addr    <= RESET_PC;
            r_discard <= 1'b0;
            r_count   <= '0;
        end else begin
            r_pc    <= w_pc_next;
            r_count <= w_count_next;
            case (r_state)
                S_IDLE: begin
                    if (w_go_idle) begin
                        r_state <= S_REQ;
                        r_addr  <= r_pc;
                    end
                end
                S_REQ: begin
                    if (w_ack) begin
                        r_discard <= 1'b0;
                        if (w_go_ack) begin
                            r_addr <= w_pc_next;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (redirect) begin
                        r_discard <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else if (redirect) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_fifo_instr[r_wptr] <= mem_rdata;
                r_fifo_pc[r_wptr]    <= r_addr;
                r_wptr               <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign mem_req         = (r_state == S_REQ);
    assign mem_addr        = r_addr;
    assign out_valid       = (r_count != '0);
    assign out_instruction = r_fifo_instr[r_rptr];
    assign out_pc          = r_fifo_pc[r_rptr];

endmodule
